video_text_ram_attr: RTL and testbench

// Dual-ported text-mode video memory: each cell is an 8-bit char code plus an 8-bit colour attribute.
// - Bus side: 32-bit CPU slave port, two cells per word.
// - Display side: one-cycle cell fetch port for a character/pixel generator.
// - Adds a hardware vertical scroll register (row-granular, with wrap-around).
// - Display fetch has absolute priority over CPU reads.

---
 rtl/video_text_ram_attr.sv | 169 ++++++++++++++++
 tb/tb_video_text_ram_attr.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_text_ram_attr.sv
// Text-mode video RAM: char+attribute cells, 32-bit bus port, display fetch port, row scroll.
// Optional blinking cursor attribute swap is built when CURSOR_EN is defined.
module video_text_ram_attr #(
    parameter int COLS = 100,
    parameter int ROWS = 37,
    parameter int AW = 16,
    parameter int BLINK_DIV = 2**24,
    localparam int CW = $clog2(COLS*ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req,
    output logic          rd_gnt,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          wr_req,
    output logic          wr_gnt,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_be,
    input  logic          disp_req,
    input  logic [CW-1:0] disp_addr,
    output logic          disp_valid,
    output logic [7:0]    disp_char,
    output logic [7:0]    disp_attr
);
    localparam int CELLS = COLS*ROWS;
    localparam int NWORDS = CELLS/2;
    localparam int WW = CW-1;
    localparam int SW = $clog2(ROWS);
    localparam logic [CW:0] CELLS_X = (CW+1)'(CELLS);
    localparam logic [CW-1:0] CELLS_C = CW'(CELLS);
    localparam logic [WW-1:0] NW_C = WW'(NWORDS);
    localparam logic [31:0] ROWS_W = 32'(ROWS);
    localparam logic [31:0] COLS_W = 32'(COLS);

    logic [31:0]   mem [NWORDS];
    logic [31:0]   ram_q;
    logic [SW-1:0] scroll;
    logic [CW-1:0] scroll_base;
    logic [CW-1:0] cursor_val;
    logic          cur_hit;
    logic          p0_q;
    logic          oob_q;
    logic          cur_q;
    logic          rd_ram_q;
    logic [31:0]   ctrl_q;
    logic [31:0]   ctrl_rd;

    logic [CW:0]   p_sum;
    logic [CW:0]   p_wrap;
    logic [CW-1:0] p;
    logic          oob;
    logic [WW-1:0] rd_word;
    logic [WW-1:0] wr_word;
    logic [WW-1:0] raddr;
    logic          raddr_ok;
    logic          wr_ctl;
    logic          rd_ctl;
    logic          wr_mem;
    logic          scroll_wr;
    logic [15:0]   lane;
    logic          hit;

    assign p_sum = {1'b0, disp_addr} + {1'b0, scroll_base};
    assign p_wrap = (p_sum >= CELLS_X) ? p_sum - CELLS_X : p_sum;
    assign p = p_wrap[CW-1:0];
    assign oob = disp_addr >= CELLS_C;

    assign rd_word = rd_addr[CW:2];
    assign wr_word = wr_addr[CW:2];
    assign rd_ctl = rd_addr[AW-1];
    assign wr_ctl = wr_addr[AW-1];

    assign rd_gnt = rd_req & ~disp_req;
    assign wr_gnt = wr_req;

    // Single RAM read port: the display fetch always wins it.
    assign raddr = disp_req ? p[CW-1:1] : rd_word;
    assign raddr_ok = raddr < NW_C;
    assign wr_mem = wr_req & ~wr_ctl & (wr_word < NW_C);
    assign scroll_wr = wr_req & wr_ctl & ~wr_addr[2] & (wr_data < ROWS_W);

    assign ctrl_rd = rd_addr[2] ? 32'(cursor_val) : 32'(scroll);

    always_ff @(posedge clk) begin
        if (wr_mem) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_word][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        ram_q <= raddr_ok ? mem[raddr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_valid  <= 1'b0;
            p0_q        <= 1'b0;
            oob_q       <= 1'b0;
            cur_q       <= 1'b0;
            rd_ram_q    <= 1'b0;
            ctrl_q      <= '0;
            scroll      <= '0;
            scroll_base <= '0;
        end else begin
            disp_valid <= disp_req;
            p0_q       <= p[0];
            oob_q      <= oob;
            cur_q      <= cur_hit;
            if (rd_gnt) begin
                rd_ram_q <= ~rd_ctl;
                ctrl_q   <= ctrl_rd;
            end
            if (scroll_wr) begin
                scroll      <= wr_data[SW-1:0];
                scroll_base <= CW'(32'(wr_data[SW-1:0]) * COLS_W);
            end
        end
    end

`ifdef CURSOR_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV-1);

    logic [CW-1:0] cursor;
    logic [BW-1:0] blink_cnt;
    logic          blink;

    always_ff @(posedge clk) begin
        if (rst) begin
            cursor    <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            if (wr_req & wr_ctl & wr_addr[2]) begin
                cursor <= wr_data[CW-1:0];
            end
            if (blink_cnt == BLAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign cursor_val = cursor;
    assign cur_hit = blink & (disp_addr == cursor);
`else
    logic unused_blink;
    assign unused_blink = 1'(BLINK_DIV);
    assign cursor_val = '0;
    assign cur_hit = 1'b0;
`endif

    // Word holds {attr1, char1, attr0, char0}; latched p[0] picks the cell.
    assign lane = p0_q ? ram_q[31:16] : ram_q[15:0];
    assign hit = disp_valid & ~oob_q;
    assign disp_char = hit ? lane[7:0] : 8'h00;
    assign disp_attr = !hit ? 8'h00 :
                       cur_q ? {lane[11:8], lane[15:12]} : lane[15:8];
    assign rd_data = rd_ram_q ? ram_q : ctrl_q;

    logic unused_bits;
    assign unused_bits = ^{rd_addr[AW-2:CW+1], rd_addr[1:0],
                           wr_addr[AW-2:CW+1], wr_addr[1:0], p_wrap[CW]};
endmodule

// File: tb/tb_video_text_ram_attr.sv
// Bench for video_text_ram_attr: directed vector table, corner sequences,
// and randomized traffic checked against an array-based cell model.
module tb_video_text_ram_attr;
    localparam int NCELL = 3700;
    localparam int NW = 1850;
    localparam int OP_WR = 0;
    localparam int OP_CTL = 1;
    localparam int OP_RD = 2;
    localparam int OP_FT = 3;

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] expv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic        rd_gnt;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic        disp_valid;
    logic [7:0]  disp_char;
    logic [7:0]  disp_attr;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_m [NW];
    int scroll_m;
    int cursor_m;

    video_text_ram_attr #(
        .COLS(100), .ROWS(37), .AW(16), .BLINK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid),
        .disp_char(disp_char), .disp_attr(disp_attr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [15:0] exp_cell(input int a);
        int pc;
        logic [31:0] w;
        if (a >= NCELL) return 16'h0000;
        pc = (a + scroll_m * 100) % NCELL;
        w = mem_m[pc / 2];
        if (pc % 2 == 1) return {w[23:16], w[31:24]};
        return {w[7:0], w[15:8]};
    endfunction

    function automatic logic [31:0] exp_ctl(input logic [15:0] a);
        return a[2] ? 32'(cursor_m) : 32'(scroll_m);
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d,
                               input logic [3:0] be);
        int w;
        if (a[15]) begin
            if (!a[2]) begin
                if (d < 37) scroll_m = int'(d);
            end else begin
`ifdef CURSOR_EN
                cursor_m = int'(d[11:0]);
`endif
            end
        end else begin
            w = int'(a[12:2]);
            if (w < NW) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[w][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_req = 1'b0;
        model_write(a, d, be);
    endtask

    task automatic do_read(input logic [15:0] a, output logic [31:0] d);
        rd_req = 1'b1; rd_addr = a; disp_req = 1'b0;
        #1;
        check("rd_gnt_idle", 32'(rd_gnt), 32'd1);
        tick();
        rd_req = 1'b0;
        d = rd_data;
    endtask

    task automatic do_fetch(input logic [11:0] a, output logic [16:0] r);
        disp_req = 1'b1; disp_addr = a;
        tick();
        r = {disp_valid, disp_char, disp_attr};
        disp_req = 1'b0;
    endtask

    vec_t tbl [16];

    initial begin
        logic [31:0] got;
        logic [16:0] fr;
        logic [31:0] old;
        logic [31:0] nw;
        int w;
        int gnt_seen;
        int n;
        logic [11:0] a;

        tbl[0]  = '{OP_WR,  16'h0000, 32'h1F41_0742, 32'h0};
        tbl[1]  = '{OP_WR,  16'h00C8, 32'hA5C3_2B6D, 32'h0};
        tbl[2]  = '{OP_WR,  16'h1CE4, 32'h1122_3344, 32'h0};
        tbl[3]  = '{OP_WR,  16'h00C4, 32'h7788_99AA, 32'h0};
        tbl[4]  = '{OP_FT,  16'd0,    32'h0,         32'h4207};
        tbl[5]  = '{OP_FT,  16'd1,    32'h0,         32'h411F};
        tbl[6]  = '{OP_CTL, 16'h8000, 32'd1,         32'h0};
        tbl[7]  = '{OP_RD,  16'h8000, 32'h0,         32'd1};
        tbl[8]  = '{OP_FT,  16'd0,    32'h0,         32'h6D2B};
        tbl[9]  = '{OP_FT,  16'd3699, 32'h0,         32'h8877};
        tbl[10] = '{OP_FT,  16'd3599, 32'h0,         32'h2211};
        tbl[11] = '{OP_CTL, 16'h8000, 32'd37,        32'h0};
        tbl[12] = '{OP_RD,  16'h8000, 32'h0,         32'd1};
        tbl[13] = '{OP_FT,  16'd3700, 32'h0,         32'h0000};
        tbl[14] = '{OP_CTL, 16'h8000, 32'd0,         32'h0};
        tbl[15] = '{OP_RD,  16'h0000, 32'h0,         32'h1F41_0742};

        scroll_m = 0; cursor_m = 0;
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; wr_be = '0;
        disp_req = 1'b0; disp_addr = '0;
        tick(); tick();
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_disp_valid", 32'(disp_valid), 32'h0);
        check("rst_disp_cell", {16'h0, disp_char, disp_attr}, 32'h0);
        rst = 1'b0;
        tick();
        check("wr_gnt_idle", 32'(wr_gnt), 32'h0);
        do_read(16'h8000, got);
        check("rst_scroll", got, 32'h0);

        for (int i = 0; i < NW; i++) do_write(16'(i * 4), $urandom, 4'hF);

        do_write(16'h8004, 32'd4095, 4'hF);
        do_read(16'h8004, got);
        check("cursor_rb", got, exp_ctl(16'h8004));

        for (int i = 0; i < 16; i++) begin
            case (tbl[i].op)
                OP_WR, OP_CTL: do_write(tbl[i].addr, tbl[i].data, 4'hF);
                OP_RD: begin
                    do_read(tbl[i].addr, got);
                    check($sformatf("vec%0d_rd", i), got, tbl[i].expv);
                end
                default: begin
                    do_fetch(tbl[i].addr[11:0], fr);
                    check($sformatf("vec%0d_ft", i), 32'(fr),
                          {15'h0, 1'b1, tbl[i].expv[15:0]});
                end
            endcase
        end

        // back-to-back fetch of cells 0 and 1
        disp_req = 1'b1; disp_addr = 12'd0;
        tick();
        check("b2b_0", {15'h0, disp_valid, disp_char, disp_attr}, 32'h1_4207);
        disp_addr = 12'd1;
        tick();
        check("b2b_1", {15'h0, disp_valid, disp_char, disp_attr}, 32'h1_411F);
        disp_req = 1'b0;
        tick();
        check("b2b_idle", 32'(disp_valid), 32'h0);

        // display holds off bus reads
        w = $urandom_range(0, NW - 1);
        rd_req = 1'b1; rd_addr = 16'(w * 4);
        disp_req = 1'b1; disp_addr = 12'd7;
        gnt_seen = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rd_gnt) gnt_seen++;
            tick();
        end
        check("stall_gnt", 32'(gnt_seen), 32'h0);
        disp_req = 1'b0;
        #1;
        check("stall_release", 32'(rd_gnt), 32'h1);
        tick();
        rd_req = 1'b0;
        check("stall_rd_data", rd_data, mem_m[w]);

        // read-before-write on the display port
        old = mem_m[3]; nw = ~old;
        wr_req = 1'b1; wr_addr = 16'd12; wr_data = nw; wr_be = 4'hF;
        disp_req = 1'b1; disp_addr = 12'd6;
        tick();
        wr_req = 1'b0;
        check("rbw_disp_old", {16'h0, disp_char, disp_attr},
              {16'h0, old[7:0], old[15:8]});
        model_write(16'd12, nw, 4'hF);
        tick();
        disp_req = 1'b0;
        check("rbw_disp_new", {16'h0, disp_char, disp_attr},
              {16'h0, nw[7:0], nw[15:8]});

        // read-before-write on the bus port
        old = mem_m[3]; nw = $urandom;
        wr_req = 1'b1; wr_addr = 16'd12; wr_data = nw; wr_be = 4'b0101;
        rd_req = 1'b1; rd_addr = 16'd12;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        check("rbw_bus_old", rd_data, old);
        model_write(16'd12, nw, 4'b0101);
        do_read(16'd12, got);
        check("rbw_bus_new", got, mem_m[3]);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: do_write(16'($urandom_range(0, 2047) * 4), $urandom,
                                  4'($urandom_range(0, 15)));
                3: do_write(16'h8000, 32'($urandom_range(0, 45)), 4'hF);
                4: begin
                    do_read(16'h8000, got);
                    check("rnd_scroll", got, exp_ctl(16'h8000));
                end
                5: begin
                    w = $urandom_range(0, NW - 1);
                    do_read(16'(w * 4), got);
                    check("rnd_rd", got, mem_m[w]);
                end
                default: begin
                    n = $urandom_range(1, 4);
                    for (int j = 0; j < n; j++) begin
                        a = 12'($urandom_range(0, 3750));
                        disp_req = 1'b1; disp_addr = a;
                        tick();
                        check("rnd_ft", {15'h0, disp_valid, disp_char, disp_attr},
                              {15'h0, 1'b1, exp_cell(int'(a))});
                    end
                    disp_req = 1'b0;
                    tick();
                    check("rnd_ft_idle", 32'(disp_valid), 32'h0);
                end
            endcase
        end

`ifdef CURSOR_EN
        do_write(16'h8000, 32'd0, 4'hF);
        do_write(16'h8004, 32'd5, 4'hF);
        do_write(16'd8, 32'h1E00_0000, 4'b1000);
        do_read(16'h8004, got);
        check("cursor_5", got, 32'd5);
        begin
            int sw_n;
            int bad;
            sw_n = 0; bad = 0;
            disp_req = 1'b1; disp_addr = 12'd5;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (disp_attr == 8'hE1) sw_n++;
                else if (disp_attr != 8'h1E) bad++;
            end
            disp_req = 1'b0;
            check("blink_swaps", 32'(sw_n), 32'd4);
            check("blink_attr", 32'(bad), 32'd0);
        end
`endif

        // reset during an in-flight fetch
        do_write(16'h8000, 32'd5, 4'hF);
        disp_req = 1'b1; disp_addr = 12'd2;
        tick();
        check("pre_rst_ft", {15'h0, disp_valid, disp_char, disp_attr},
              {15'h0, 1'b1, exp_cell(2)});
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(disp_valid), 32'h0);
        check("midrst_cell", {16'h0, disp_char, disp_attr}, 32'h0);
        check("midrst_rd", rd_data, 32'h0);
        rst = 1'b0; disp_req = 1'b0;
        scroll_m = 0; cursor_m = 0;
        do_read(16'h8000, got);
        check("post_rst_scroll", got, 32'h0);
        do_fetch(12'd0, fr);
        check("post_rst_ft", 32'(fr), {15'h0, 1'b1, exp_cell(0)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
